// File: rtl/bitwise_logic_unit.sv
// Two-stage streaming bitwise logic unit: S1 holds operands, S2 holds result plus zero/parity flags.
// Optional accumulator feedback operand is compiled in when BLU_ACC_EN is defined.
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BLU_ACC_EN
  input  logic             acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_NOTB = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             accept;
  logic             s1_adv;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] y_next;
  logic             zero_next;
  logic             parity_next;

  // S2 is free when empty or draining this cycle; in_ready follows out_ready combinationally.
  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

`ifdef BLU_ACC_EN
  logic             s1_acc;
  logic [WIDTH-1:0] acc_q;

  // acc_q always holds the most recent result to enter S2, so chained words see the previous result.
  assign opnd_a = s1_acc ? acc_q : s1_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc <= 1'b0;
      acc_q  <= '0;
    end else begin
      if (accept) s1_acc <= acc;
      if (s1_adv) acc_q <= y_next;
    end
  end
`else
  assign opnd_a = s1_a;
`endif

  always_comb begin
    y_next = '0;
    case (s1_op)
      OP_AND:  y_next = opnd_a & s1_b;
      OP_OR:   y_next = opnd_a | s1_b;
      OP_XOR:  y_next = opnd_a ^ s1_b;
      OP_NAND: y_next = ~(opnd_a & s1_b);
      OP_NOR:  y_next = ~(opnd_a | s1_b);
      OP_XNOR: y_next = ~(opnd_a ^ s1_b);
      OP_NOTA: y_next = ~opnd_a;
      OP_NOTB: y_next = ~s1_b;
      default: y_next = '0;
    endcase
  end

  assign zero_next   = ~|y_next;
  assign parity_next = ^y_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= op_e'(op);
        s1_a     <= a;
        s1_b     <= b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Result registers only move on an S1 advance, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        y         <= y_next;
        zero      <= zero_next;
        parity    <= parity_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
